// File: rtl/seq_div12.sv
// Sequential restoring divider: 2*WIDTH-bit dividend / WIDTH-bit divisor, one quotient
// bit per clock, START/DONE handshake. Companion to the 6x6 Dadda multiplier.
module seq_div12 #(
    parameter int WIDTH = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [2*WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]     divisor,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   quot,
    output logic [WIDTH-1:0]     rem,
    output logic                 div0
);

    localparam int DW = 2 * WIDTH;
    localparam int CW = $clog2(DW);
    localparam logic [CW-1:0] LAST_STEP = CW'(DW - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIN
    } state_t;

    state_t             state_reg, state_next;
    logic [CW-1:0]      count_reg, count_next;
    // Dividend bits shift out of the MSB while quotient bits shift in at the LSB.
    logic [DW-1:0]      shift_reg, shift_next;
    logic [WIDTH-1:0]   dvs_reg, dvs_next;
    logic [WIDTH-1:0]   prem_reg, prem_next;
    logic               zero_reg, zero_next;
    logic [DW-1:0]      quot_reg, quot_next;
    logic [WIDTH-1:0]   rem_reg, rem_next;
    logic               div0_reg, div0_next;

    logic [WIDTH:0]     partial;
    logic               q_bit;
    logic [WIDTH-1:0]   step_rem;

    // One restoring step on the current working registers.
    always_comb begin
        partial  = {prem_reg, shift_reg[DW-1]};
        q_bit    = (partial >= {1'b0, dvs_reg});
        step_rem = q_bit ? WIDTH'(partial - {1'b0, dvs_reg}) : partial[WIDTH-1:0];
    end

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        shift_next = shift_reg;
        dvs_next   = dvs_reg;
        prem_next  = prem_reg;
        zero_next  = zero_reg;
        quot_next  = quot_reg;
        rem_next   = rem_reg;
        div0_next  = div0_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    shift_next = dividend;
                    dvs_next   = divisor;
                    prem_next  = '0;
                    count_next = '0;
                    zero_next  = (divisor == '0);
                    if (divisor != '0) begin
                        div0_next = 1'b0;
                    end
                    state_next = CALC;
                end
            end
            CALC: begin
                if (zero_reg) begin
                    quot_next  = '1;
                    rem_next   = '0;
                    div0_next  = 1'b1;
                    state_next = FIN;
                end else begin
                    shift_next = {shift_reg[DW-2:0], q_bit};
                    prem_next  = step_rem;
                    count_next = count_reg + CW'(1);
                    if (count_reg == LAST_STEP) begin
                        quot_next  = {shift_reg[DW-2:0], q_bit};
                        rem_next   = step_rem;
                        count_next = '0;
                        state_next = FIN;
                    end
                end
            end
            FIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            count_reg <= '0;
            shift_reg <= '0;
            dvs_reg   <= '0;
            prem_reg  <= '0;
            zero_reg  <= 1'b0;
            quot_reg  <= '0;
            rem_reg   <= '0;
            div0_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            shift_reg <= shift_next;
            dvs_reg   <= dvs_next;
            prem_reg  <= prem_next;
            zero_reg  <= zero_next;
            quot_reg  <= quot_next;
            rem_reg   <= rem_next;
            div0_reg  <= div0_next;
        end
    end

    assign busy = (state_reg != IDLE);
    assign done = (state_reg == FIN);
    assign quot = quot_reg;
    assign rem  = rem_reg;
    assign div0 = div0_reg;

endmodule

// File: tb/tb_seq_div12.sv
// Randomized self-checking bench for seq_div12 against a plain-arithmetic division model.
module tb_seq_div12;

    localparam int WIDTH = 6;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              start = 1'b0;
    logic [11:0]       dividend = '0;
    logic [5:0]        divisor = '0;
    logic              busy;
    logic              done;
    logic [11:0]       quot;
    logic [5:0]        rem;
    logic              div0;

    int n_assert = 0;
    int n_fail   = 0;
    int prev_q   = 0;

    seq_div12 #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .quot     (quot),
        .rem      (rem),
        .div0     (div0)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_assert++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One full transaction with latency, hold, result and pulse-width checks.
    task automatic run_op(input int a, input int b);
        int  eq, er, ediv0, elat, k;
        bit  seen;
        if (b == 0) begin
            eq = 4095; er = 0; ediv0 = 1; elat = 1;
        end else begin
            eq = a / b; er = a % b; ediv0 = 0; elat = 12;
        end
        @(negedge clk);
        dividend = 12'(a);
        divisor  = 6'(b);
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = 12'($urandom);
        divisor  = 6'($urandom);
        check("busy_after_accept", int'(busy), 1);
        seen = 1'b0;
        k    = 0;
        while (!seen && k < 40) begin
            @(posedge clk);
            #1;
            k++;
            if (done) seen = 1'b1;
            else check("quot_hold_calc", int'(quot), prev_q);
        end
        check("done_seen", int'(seen), 1);
        if (seen) begin
            check("latency", k, elat);
            check("quot", int'(quot), eq);
            check("rem", int'(rem), er);
            check("div0", int'(div0), ediv0);
            if (b != 0) begin
                check("identity", int'(quot) * b + int'(rem), a);
                check("rem_lt_divisor", int'(rem < 6'(b)), 1);
            end
        end
        @(posedge clk);
        #1;
        check("done_one_cycle", int'(done), 0);
        check("busy_end", int'(busy), 0);
        $display("op %0d/%0d -> quot=%0d rem=%0d div0=%0d lat=%0d (model %0d r%0d)",
                 a, b, quot, rem, div0, k, eq, er);
        prev_q = eq;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int dcnt, gq, gr;

        // Reset values
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_quot", int'(quot), 0);
        check("rst_rem", int'(rem), 0);
        check("rst_div0", int'(div0), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed operations
        run_op(4095, 63);
        run_op(100, 7);
        run_op(1, 63);
        run_op(25, 0);
        run_op(3969, 63);

        // Second START during CALC is dropped
        @(negedge clk);
        dividend = 12'd100; divisor = 6'd7; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1; dividend = 12'd50; divisor = 6'd5;
        @(posedge clk);
        #1 start = 1'b0;
        check("busy_ignored_start", int'(busy), 1);
        dcnt = 0; gq = 0; gr = 0;
        for (int i = 0; i < 25; i++) begin
            if (done) begin
                dcnt++; gq = int'(quot); gr = int'(rem);
            end
            @(posedge clk);
            #1;
        end
        check("drop_done_count", dcnt, 1);
        check("drop_quot", gq, 14);
        check("drop_rem", gr, 2);
        $display("op 100/7 with dropped 50/5 -> dones=%0d quot=%0d rem=%0d", dcnt, gq, gr);
        prev_q = 14;

        // Asynchronous abort mid-operation
        @(negedge clk);
        dividend = 12'd4095; divisor = 6'd63; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_quot", int'(quot), 0);
        check("abort_rem", int'(rem), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        dcnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (done) dcnt++;
        end
        check("abort_no_done", dcnt, 0);
        $display("abort of 4095/63 at edge 5 -> dones after release=%0d", dcnt);
        prev_q = 0;
        run_op(100, 7);

        // Boundary corners then a random sweep
        run_op(0, 1);
        run_op(4095, 1);
        run_op(0, 63);
        run_op(63, 63);
        run_op(62, 63);
        run_op(4095, 0);
        for (int i = 0; i < 60; i++) begin
            run_op(int'($urandom_range(0, 4095)), int'($urandom_range(0, 63)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
